// File: rtl/prime_candidate_sieve.sv
// prime_candidate_sieve
//   Produces odd WIDTH-bit candidates with the MSB set that have no factor
//   in {3,5,7,11,13,17,19,23,29,31}. Candidates are drawn from a 64-bit
//   Galois LFSR. They are reduced bit-serially against all ten small
//   primes in parallel. They are then stepped by +2 until the sieve passes.
//
//   Ports
//     clk        rising-edge clock for all state
//     rst_n      asynchronous active-low reset
//     en         search enable (sampled in IDLE and at the output handshake)
//     seed_we    load LFSR from seed_in (IDLE only, non-zero values only)
//     seed_in    64-bit LFSR load value
//     out_valid  candidate available
//     out_ready  downstream accepts
//     out_data   current / last candidate
//     busy       high in any state other than IDLE
//     reject_cnt saturating count of sieve rejects (PRIME_SIEVE_STATS_EN only)
//
//   Optional feature macro: PRIME_SIEVE_STATS_EN
module prime_candidate_sieve #(
   parameter int unsigned WIDTH = 64,
   parameter logic [63:0] SEED  = 64'hACE1_0000_0000_0001
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             seed_we,
   input  logic [63:0]      seed_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
`ifdef PRIME_SIEVE_STATS_EN
   ,
   output logic [15:0]      reject_cnt
`endif
);

   localparam logic [63:0]      SEED_DEFAULT = 64'hACE1_0000_0000_0001;
   localparam logic [63:0]      SEED_EFF     = (SEED == 64'd0) ? SEED_DEFAULT : SEED;
   // x^64+x^63+x^61+x^60+1, right-shifting Galois form
   localparam logic [63:0]      LFSR_TAPS    = 64'hD800_0000_0000_0000;
   localparam int unsigned      NP           = 10;
   localparam logic [4:0]       PRIMES [NP]  = '{5'd3, 5'd5, 5'd7, 5'd11, 5'd13,
                                                 5'd17, 5'd19, 5'd23, 5'd29, 5'd31};
   localparam logic [6:0]       CNT_LAST     = 7'(WIDTH - 1);
   localparam logic [WIDTH-1:0] CAND_FORCE   = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_REDUCE,
      S_CHECK,
      S_STEP,
      S_OFFER
   } state_t;

   state_t           state_q, state_d;
   logic [63:0]      lfsr_q, lfsr_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [4:0]       rem_q [NP];
   logic [4:0]       rem_d [NP];
   logic [6:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;

   logic [63:0]      lfsr_adv;
   logic             seed_load;
   logic             all_nz;

   // Inputs are always below 2p, so one conditional subtract is a full mod.
   function automatic logic [4:0] mod_fold(input logic [5:0] t, input logic [4:0] p);
      return (t >= {1'b0, p}) ? 5'(t - {1'b0, p}) : t[4:0];
   endfunction

   assign lfsr_adv  = {1'b0, lfsr_q[63:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 64'd0);
   assign seed_load = (state_q == S_IDLE) && seed_we && (seed_in != '0);

   always_comb begin
      all_nz = 1'b1;
      for (int unsigned i = 0; i < NP; i++) begin
         if (rem_q[i] == 5'd0) all_nz = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      lfsr_d  = (state_q == S_IDLE) ? lfsr_q : lfsr_adv;
      cand_d  = cand_q;
      sh_d    = sh_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      data_d  = data_q;

      case (state_q)
         S_IDLE: begin
            if (seed_load) lfsr_d = seed_in;
            if (en) state_d = S_LOAD;
         end
         S_LOAD: begin
            cand_d = lfsr_q[WIDTH-1:0] | CAND_FORCE;
            sh_d   = lfsr_q[WIDTH-1:0] | CAND_FORCE;
            for (int unsigned i = 0; i < NP; i++) rem_d[i] = 5'd0;
            cnt_d   = '0;
            state_d = S_REDUCE;
         end
         S_REDUCE: begin
            // sh_q is a working copy of cand shifted MSB-first; cand is kept intact.
            for (int unsigned i = 0; i < NP; i++) begin
               rem_d[i] = mod_fold({rem_q[i], sh_q[WIDTH-1]}, PRIMES[i]);
            end
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == CNT_LAST) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (all_nz) begin
               data_d  = cand_q;
               state_d = S_OFFER;
            end else begin
               state_d = S_STEP;
            end
         end
         S_STEP: begin
            if (cand_q == '1) begin
               state_d = S_LOAD;
            end else begin
               cand_d = cand_q + WIDTH'(2);
               for (int unsigned i = 0; i < NP; i++) begin
                  rem_d[i] = mod_fold({1'b0, rem_q[i]} + 6'd2, PRIMES[i]);
               end
               state_d = S_CHECK;
            end
         end
         S_OFFER: begin
            if (out_ready) state_d = en ? S_LOAD : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         lfsr_q  <= SEED_EFF;
         cand_q  <= '0;
         sh_q    <= '0;
         rem_q   <= '{default: '0};
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cand_q  <= cand_d;
         sh_q    <= sh_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = (state_q == S_OFFER);
   assign out_data  = data_q;
   assign busy      = (state_q != S_IDLE);

`ifdef PRIME_SIEVE_STATS_EN
   logic [15:0] rej_q, rej_d;

   always_comb begin
      rej_d = rej_q;
      if (seed_load) begin
         rej_d = '0;
      end else if ((state_q == S_CHECK) && !all_nz && (rej_q != '1)) begin
         rej_d = rej_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rej_q <= '0;
      else        rej_q <= rej_d;
   end

   assign reject_cnt = rej_q;
`endif

endmodule

// File: tb/tb_prime_candidate_sieve.sv
module tb_prime_candidate_sieve;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;

   logic        a_en, a_seed_we, a_out_ready, a_out_valid, a_busy;
   logic [63:0] a_seed_in;
   logic [15:0] a_out_data;

   logic        b_en, b_seed_we, b_out_ready, b_out_valid, b_busy;
   logic [63:0] b_seed_in;
   logic [31:0] b_out_data;

`ifdef PRIME_SIEVE_STATS_EN
   logic [15:0] a_reject_cnt, b_reject_cnt;
`endif

   prime_candidate_sieve #(.WIDTH(16)) u16 (
      .clk(clk), .rst_n(rst_n), .en(a_en), .seed_we(a_seed_we), .seed_in(a_seed_in),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
`ifdef PRIME_SIEVE_STATS_EN
      , .reject_cnt(a_reject_cnt)
`endif
   );

   prime_candidate_sieve #(.WIDTH(32)) u32 (
      .clk(clk), .rst_n(rst_n), .en(b_en), .seed_we(b_seed_we), .seed_in(b_seed_in),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
`ifdef PRIME_SIEVE_STATS_EN
      , .reject_cnt(b_reject_cnt)
`endif
   );

   int checks   = 0;
   int failures = 0;
   logic [15:0] exp_q [$];

   typedef struct {
      logic [15:0] seed;
      logic [15:0] exp_data;
      int          lat;
      int          rej;
   } vec_t;

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   function automatic bit sieve_ok(input logic [63:0] v);
      int unsigned pr [10] = '{3, 5, 7, 11, 13, 17, 19, 23, 29, 31};
      for (int i = 0; i < 10; i++) begin
         if ((v % 64'(pr[i])) == 64'd0) return 1'b0;
      end
      return 1'b1;
   endfunction

   // One search on the 16-bit instance with out_ready held high; en is
   // dropped right after it is sampled so the block returns to IDLE.
   task automatic run16(input logic [15:0] seed, input bit load, input bit scored,
                        output int lat, output logic [15:0] got);
      int k;
      @(negedge clk);
      a_seed_we   = load;
      a_seed_in   = {48'd0, seed};
      a_en        = 1'b1;
      a_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_seed_we = 1'b0;
      a_en      = 1'b0;
      k   = 0;
      lat = -1;
      got = '0;
      while (k < 400 && lat < 0) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (a_out_valid) lat = k;
      end
      if (lat < 0) begin
         fail_now("timeout16");
         return;
      end
      got = a_out_data;
      if (scored) begin
         if (exp_q.size() == 0) fail_now("sb_empty");
         else check_val("sb_data16", {48'd0, got}, {48'd0, exp_q.pop_front()});
      end
      @(posedge clk);
      @(negedge clk);
      check_val("valid_drop", {63'd0, a_out_valid}, 64'd0);
      check_val("idle_after", {63'd0, a_busy}, 64'd0);
      check_val("data_hold", {48'd0, a_out_data}, {48'd0, got});
   endtask

   initial begin
      vec_t        vecs [4];
      int          lat;
      logic [15:0] got;
      int          xfers;
      int          hs;
      bit          prev_hold;
      logic [31:0] prev_data;
      bit          ok;

      vecs[0] = '{seed: 16'h8001, exp_data: 16'h8003, lat: 20, rej: 1};
      vecs[1] = '{seed: 16'h0003, exp_data: 16'h8003, lat: 18, rej: 0};
      vecs[2] = '{seed: 16'h8005, exp_data: 16'h8009, lat: 22, rej: 2};
      vecs[3] = '{seed: 16'h1234, exp_data: 16'h9241, lat: 30, rej: 6};

      rst_n = 1'b0;
      a_en = 0; a_seed_we = 0; a_seed_in = '0; a_out_ready = 0;
      b_en = 0; b_seed_we = 0; b_seed_in = '0; b_out_ready = 0;
      #23;
      check_val("rst_valid16", {63'd0, a_out_valid}, 64'd0);
      check_val("rst_busy16", {63'd0, a_busy}, 64'd0);
      check_val("rst_data16", {48'd0, a_out_data}, 64'd0);
      check_val("rst_valid32", {63'd0, b_out_valid}, 64'd0);
      check_val("rst_data32", {32'd0, b_out_data}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven vectors on the 16-bit instance
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(vecs[i].exp_data);
         run16(vecs[i].seed, 1'b1, 1'b1, lat, got);
         check_val("latency16", 64'(lat), 64'(vecs[i].lat));
         check_val("sieve16", {63'd0, sieve_ok({48'd0, got})}, 64'd1);
`ifdef PRIME_SIEVE_STATS_EN
         check_val("reject_cnt", {48'd0, a_reject_cnt}, 64'(vecs[i].rej));
`endif
      end

      // All-ones seed: rejected, wraps to a fresh draw
      run16(16'hFFFF, 1'b1, 1'b0, lat, got);
      check_val("wrap_not1", {63'd0, (got == 16'h0001)}, 64'd0);
      check_val("wrap_msb", {63'd0, got[15]}, 64'd1);
      check_val("wrap_odd", {63'd0, got[0]}, 64'd1);
      check_val("wrap_sieve", {63'd0, sieve_ok({48'd0, got})}, 64'd1);
      check_val("wrap_slower", {63'd0, (lat > 20)}, 64'd1);

      // Backpressure: 10 stalled cycles, then exactly one transfer
      exp_q.push_back(16'h8003);
      @(negedge clk);
      a_seed_we = 1'b1; a_seed_in = 64'h3; a_en = 1'b1; a_out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      a_seed_we = 1'b0; a_en = 1'b0;
      lat = -1;
      for (int k = 1; k <= 400 && lat < 0; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (a_out_valid) lat = k;
      end
      if (lat < 0) fail_now("timeout_bp");
      check_val("bp_data", {48'd0, a_out_data}, 64'h8003);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         @(negedge clk);
         check_val("bp_valid_hold", {63'd0, a_out_valid}, 64'd1);
         check_val("bp_data_hold", {48'd0, a_out_data}, 64'h8003);
      end
      a_out_ready = 1'b1;
      xfers = 0;
      for (int k = 0; k < 6; k++) begin
         if (a_out_valid && a_out_ready) begin
            xfers++;
            if (exp_q.size() == 0) fail_now("sb_empty_bp");
            else check_val("sb_data_bp", {48'd0, a_out_data}, {48'd0, exp_q.pop_front()});
         end
         @(posedge clk);
         @(negedge clk);
      end
      check_val("bp_one_xfer", 64'(xfers), 64'd1);

      // Reset pulse in REDUCE cycle 5, then restart from SEED
      @(negedge clk);
      a_en = 1'b1;
      @(posedge clk);
      repeat (5) @(posedge clk);
      #2;
      check_val("busy_before_rst", {63'd0, a_busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      check_val("rst_mid_valid", {63'd0, a_out_valid}, 64'd0);
      check_val("rst_mid_busy", {63'd0, a_busy}, 64'd0);
      check_val("rst_mid_data", {48'd0, a_out_data}, 64'd0);
      @(negedge clk);
      a_en  = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_val("wait_idle", {63'd0, a_busy}, 64'd0);
      exp_q.push_back(16'h8003);
      run16(16'h0000, 1'b0, 1'b1, lat, got);
      check_val("seed_latency", 64'(lat), 64'd20);

      // Continuous 32-bit run with random backpressure
      b_en      = 1'b1;
      hs        = 0;
      prev_hold = 1'b0;
      prev_data = '0;
      for (int cyc = 0; cyc < 90000 && hs < 1000; cyc++) begin
         @(negedge clk);
         if (prev_hold) begin
            check_val("hold32_valid", {63'd0, b_out_valid}, 64'd1);
            check_val("hold32_data", {32'd0, b_out_data}, {32'd0, prev_data});
         end
         b_out_ready = ($urandom_range(0, 7) != 0);
         if (b_out_valid) begin
            if (b_out_ready) begin
               hs++;
               ok = b_out_data[0] && b_out_data[31] && sieve_ok({32'd0, b_out_data});
               if (!ok) $display("FAIL cand32: got 0x%0h required odd, MSB set, no factor <= 31", b_out_data);
               check_val("cand32", {63'd0, ok}, 64'd1);
            end
            prev_hold = !b_out_ready;
            prev_data = b_out_data;
         end else begin
            prev_hold = 1'b0;
         end
      end
      check_val("handshakes32", 64'(hs), 64'd1000);
      b_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prime_candidate_sieve.md
PRIME_CANDIDATE_SIEVE -- requirements
Module: prime_candidate_sieve

Interface
REQ-001 SHALL have parameter WIDTH, default 64, candidate width in bits; legal range 16..64.
REQ-002 SHALL have parameter SEED, default 64'hACE1_0000_0000_0001, LFSR reset value; a value of 0 SHALL be replaced by the default.
REQ-003 SHALL have port clk, input, 1, the single clock for all state, rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, search enable.
REQ-006 SHALL have port seed_we, input, 1, loads the LFSR from seed_in; honoured in IDLE only.
REQ-007 SHALL have port seed_in, input, 64, LFSR load value.
REQ-008 SHALL have port out_valid, output, 1, candidate available.
REQ-009 SHALL have port out_ready, input, 1, downstream primality tester accepts.
REQ-010 SHALL have port out_data, output, WIDTH, odd candidate with no factor in {3,5,7,11,13,17,19,23,29,31}.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL implement a 64-bit Galois LFSR with polynomial x^64+x^63+x^61+x^60+1, advancing every clock except in IDLE; an all-zero seed_in SHALL be ignored.
REQ-013 SHALL use states IDLE, LOAD, REDUCE, CHECK, STEP and OFFER.
REQ-014 IDLE: SHALL go to LOAD when en=1; seed_we=1 in the same cycle SHALL load the LFSR first.
REQ-015 LOAD (1 cycle): cand <= lfsr[WIDTH-1:0] with bit WIDTH-1 and bit 0 forced to 1; all ten remainders cleared; then REDUCE.
REQ-016 REDUCE (exactly WIDTH cycles): processes cand MSB-first; for each prime p, r_p <= (2*r_p + bit) mod p; all ten updated in parallel using 5-bit remainders.
REQ-017 CHECK (1 cycle): if every r_p is nonzero, go to OFFER; otherwise go to STEP.
REQ-018 STEP (1 cycle): if cand equals 2^WIDTH-1, go to LOAD (wrap-around, fresh random draw); otherwise cand <= cand+2, r_p <= (r_p+2) mod p, then CHECK.
REQ-019 OFFER: out_valid=1 and out_data=cand; both SHALL hold stable while out_ready=0.
REQ-020 OFFER: on out_valid&&out_ready, go to LOAD if en=1, else IDLE; out_valid SHALL drop in the next cycle.
REQ-021 en SHALL be sampled only in IDLE and at handshake; deasserting en mid-search SHALL NOT abort the search.
REQ-022 Latency: out_valid SHALL rise WIDTH+2 cycles after the edge sampling en=1 in IDLE when the first candidate passes; each reject SHALL add 2 cycles.
REQ-023 out_data SHALL hold its last value outside OFFER.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state=IDLE, out_valid=0, out_data=0, busy=0, cand=0, all remainders=0 and lfsr=SEED.
REQ-025 Reset asserted in any state, including mid-REDUCE, SHALL discard the candidate; after release the block SHALL wait in IDLE for en.

Configuration
REQ-026 Macro PRIME_SIEVE_STATS_EN SHALL, when defined, add output reject_cnt[15:0]: +1 per CHECK-to-STEP transition, saturating at 16'hFFFF, cleared by reset and on every seed_we load.
REQ-027 Without PRIME_SIEVE_STATS_EN, the reject_cnt port and counter SHALL NOT exist and behaviour SHALL be otherwise identical.

Verification
REQ-028 WIDTH=16, seed_we with seed_in=0x8001, en=1, out_ready=1 -> 0x8001 rejected (divisible by 3); out_valid rises 20 cycles after en is sampled, with out_data=0x8003; with the macro defined, reject_cnt=1.
REQ-029 WIDTH=16, seed_in=0xFFFF -> 0xFFFF rejected, STEP wraps to LOAD; out_data SHALL NOT be 0x0001, SHALL have bit 15 set and SHALL pass the sieve.
REQ-030 Backpressure: out_ready=0 for 10 cycles in OFFER -> out_valid stays 1 and out_data stays constant; ready=1 -> exactly one transfer.
REQ-031 rst_n pulsed low during REDUCE cycle 5 -> out_valid=0 and busy=0 immediately; after release with en=1 and no seed_we, the first candidate is taken from SEED.
REQ-032 Continuous run, WIDTH=32, 1000 handshakes -> every out_data is odd, has the MSB set and has no divisor ≤31 (scoreboard check).
